// File: rtl/bash_f_core.sv
// Bash-F permutation engine: one S-layer + word permutation + constant per clock.
// Eight parallel bash_s columns feed the P shuffle; the LFSR constant lands in S[23].

module bash_s #(
   parameter int unsigned M1 = 8,
   parameter int unsigned N1 = 53,
   parameter int unsigned M2 = 14,
   parameter int unsigned N2 = 1
) (
   input  logic [63:0] w0_i,
   input  logic [63:0] w1_i,
   input  logic [63:0] w2_i,
   output logic [63:0] w0_o,
   output logic [63:0] w1_o,
   output logic [63:0] w2_o
);

   function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned n);
      return (x << n) | (x >> (64 - n));
   endfunction

   logic [63:0] t0;
   logic [63:0] t1;
   logic [63:0] u0;
   logic [63:0] u1;
   logic [63:0] u2;

   assign t0 = rotl(w0_i, M1);
   assign u0 = w0_i ^ w1_i ^ w2_i;
   assign t1 = w1_i ^ rotl(u0, N1);
   assign u1 = t0 ^ t1;
   assign u2 = w2_i ^ rotl(w2_i, M2) ^ rotl(t1, N2);

   // nonlinear mixing reads u0/u1/u2 before any of them is updated
   assign w0_o = u0 ^ (~u2 | u1);
   assign w1_o = u1 ^ (u0 | u2);
   assign w2_o = u2 ^ (u0 & u1);

endmodule

module bash_f_core #(
   parameter int unsigned ROUNDS = 24
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic [1535:0] state_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [1535:0] state_o
);

   localparam logic [63:0] BASH_F_INIT  = 64'hB194BAC80A08F53B;
   localparam logic [63:0] BASH_F_CONST = 64'hAED8E07F99E12BDC;
   localparam logic [4:0]  LAST_RND     = 5'(ROUNDS - 1);

   localparam int unsigned M1_BASH_S [8] = '{8, 56, 8, 56, 8, 56, 8, 56};
   localparam int unsigned N1_BASH_S [8] = '{53, 51, 37, 3, 21, 19, 5, 35};
   localparam int unsigned M2_BASH_S [8] = '{14, 34, 46, 2, 14, 34, 46, 2};
   localparam int unsigned N2_BASH_S [8] = '{1, 7, 49, 23, 33, 39, 17, 55};

   localparam int unsigned PERM [24] = '{
      15, 10, 9, 12, 11, 14, 13, 8,
      17, 16, 19, 18, 21, 20, 23, 22,
      6, 3, 0, 5, 2, 7, 4, 1
   };

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fsm_e;

   fsm_e          fsm_q;
   logic [1535:0] s_q;
   logic [1535:0] s_d;
   logic [63:0]   c_q;
   logic [63:0]   c_d;
   logic [4:0]    rnd_q;
   logic          busy_q;
   logic          done_q;

   logic [63:0] w  [24];
   logic [63:0] sl [24];

   genvar k;
   generate
      for (k = 0; k < 24; k++) begin : g_unpack
         assign w[k] = s_q[64*k +: 64];
      end

      for (k = 0; k < 8; k++) begin : g_slayer
         bash_s #(
            .M1(M1_BASH_S[k]),
            .N1(N1_BASH_S[k]),
            .M2(M2_BASH_S[k]),
            .N2(N2_BASH_S[k])
         ) u_bash_s (
            .w0_i(w[k]),
            .w1_i(w[8+k]),
            .w2_i(w[16+k]),
            .w0_o(sl[k]),
            .w1_o(sl[8+k]),
            .w2_o(sl[16+k])
         );
      end

      for (k = 0; k < 24; k++) begin : g_perm
         if (k == 23) begin : g_xc
            assign s_d[64*k +: 64] = sl[PERM[k]] ^ c_q;
         end else begin : g_pass
            assign s_d[64*k +: 64] = sl[PERM[k]];
         end
      end
   endgenerate

   assign c_d = (c_q >> 1) ^ (c_q[0] ? BASH_F_CONST : 64'h0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q  <= IDLE;
         s_q    <= '0;
         c_q    <= '0;
         rnd_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         unique case (fsm_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  fsm_q  <= RUN;
                  s_q    <= state_i;
                  c_q    <= BASH_F_INIT;
                  rnd_q  <= '0;
                  busy_q <= 1'b1;
               end else begin
                  fsm_q  <= IDLE;
               end
            end
            RUN: begin
               s_q   <= s_d;
               c_q   <= c_d;
               rnd_q <= rnd_q + 5'd1;
               if (rnd_q == LAST_RND) begin
                  fsm_q  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: begin
               fsm_q  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign state_o = s_q;

endmodule

// File: tb/tb_bash_f_core.sv
// Randomized bench for bash_f_core against an array-based Bash-F model.
// A second instance with ROUNDS=1 covers the single-round vector.

module tb_bash_f_core;

   localparam logic [63:0] INIT  = 64'hB194BAC80A08F53B;
   localparam logic [63:0] CONST = 64'hAED8E07F99E12BDC;
   localparam int M1 [8] = '{8, 56, 8, 56, 8, 56, 8, 56};
   localparam int N1 [8] = '{53, 51, 37, 3, 21, 19, 5, 35};
   localparam int M2 [8] = '{14, 34, 46, 2, 14, 34, 46, 2};
   localparam int N2 [8] = '{1, 7, 49, 23, 33, 39, 17, 55};
   localparam int PERM [24] = '{15, 10, 9, 12, 11, 14, 13, 8,
                                17, 16, 19, 18, 21, 20, 23, 22,
                                6, 3, 0, 5, 2, 7, 4, 1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          start;
   logic [1535:0] st_i;
   logic          busy;
   logic          done;
   logic [1535:0] st_o;
   logic          start1;
   logic [1535:0] st1_i;
   logic          busy1;
   logic          done1;
   logic [1535:0] st1_o;

   int n_chk  = 0;
   int n_fail = 0;

   bash_f_core #(.ROUNDS(24)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .state_i(st_i),
      .busy_o(busy), .done_o(done), .state_o(st_o)
   );

   bash_f_core #(.ROUNDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(start1), .state_i(st1_i),
      .busy_o(busy1), .done_o(done1), .state_o(st1_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
      return (x << n) | (x >> (64 - n));
   endfunction

   // Bash-S written as the sequential step list of the algorithm
   function automatic logic [191:0] bs(input logic [63:0] a, b, c, input int j);
      logic [63:0] w0, w1, w2, t0, t1, t2;
      w0 = a; w1 = b; w2 = c;
      t0 = rotl(w0, M1[j]);
      w0 = w0 ^ w1 ^ w2;
      t1 = w1 ^ rotl(w0, N1[j]);
      w1 = t0 ^ t1;
      w2 = w2 ^ rotl(w2, M2[j]) ^ rotl(t1, N2[j]);
      t0 = ~w2;
      t1 = w0 | w2;
      t2 = w0 & w1;
      t0 = t0 | w1;
      w1 = w1 ^ t1;
      w2 = w2 ^ t2;
      w0 = w0 ^ t0;
      return {w2, w1, w0};
   endfunction

   function automatic logic [1535:0] model(input logic [1535:0] x, input int rounds);
      logic [63:0]   s [24];
      logic [63:0]   t [24];
      logic [63:0]   c;
      logic [191:0]  r;
      logic [1535:0] y;
      c = INIT;
      for (int k = 0; k < 24; k++) s[k] = x[64*k +: 64];
      for (int n = 0; n < rounds; n++) begin
         for (int j = 0; j < 8; j++) begin
            r = bs(s[j], s[8+j], s[16+j], j);
            s[j] = r[63:0]; s[8+j] = r[127:64]; s[16+j] = r[191:128];
         end
         for (int k = 0; k < 24; k++) t[k] = s[PERM[k]];
         t[23] = t[23] ^ c;
         for (int k = 0; k < 24; k++) s[k] = t[k];
         c = (c >> 1) ^ (c[0] ? CONST : 64'h0);
      end
      for (int k = 0; k < 24; k++) y[64*k +: 64] = s[k];
      return y;
   endfunction

   function automatic logic [1535:0] rnd_st();
      logic [1535:0] v;
      for (int k = 0; k < 48; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   function automatic int nzw(input logic [1535:0] v);
      int n = 0;
      for (int k = 0; k < 24; k++) if (v[64*k +: 64] != 64'h0) n++;
      return n;
   endfunction

   task automatic chk_state(input string tag, input logic [1535:0] obs, input logic [1535:0] exp);
      for (int k = 0; k < 24; k++)
         chk($sformatf("%s_w%0d", tag, k), obs[64*k +: 64], exp[64*k +: 64]);
   endtask

   task automatic run24(input string tag, input logic [1535:0] x, input bit disturb);
      logic [1535:0] exp;
      int n, bc;
      bit got;
      exp = model(x, 24);
      @(negedge clk);
      start = 1'b1; st_i = x;
      @(negedge clk);
      start = 1'b0; st_i = rnd_st();
      n = 1; bc = 0; got = 1'b0;
      while (n <= 40 && !got) begin
         if (done) begin
            got = 1'b1;
         end else begin
            if (busy) bc++;
            if (disturb && (n - 1 == 3 || n - 1 == 12 || n - 1 == 23)) begin
               start = 1'b1; st_i = rnd_st();
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            n++;
         end
      end
      start = 1'b0;
      if (!got) chk({tag, "_done_seen"}, 64'(0), 64'(1));
      else begin
         chk({tag, "_latency"}, 64'(n), 64'(25));
         chk({tag, "_busy_cycles"}, 64'(bc), 64'(24));
         chk_state(tag, st_o, exp);
         @(negedge clk);
         chk({tag, "_done_pulse"}, 64'(done), 64'(0));
      end
   endtask

   logic [1535:0] q [$];
   logic [1535:0] v;
   logic [1535:0] e1;
   int n, res, guard, dcount;
   bit got1;

   initial begin
      rst_n = 1'b0;
      start = 1'b0; st_i = '0;
      start1 = 1'b0; st1_i = '0;

      // reset with random inputs applied
      repeat (3) begin
         @(negedge clk);
         start = 1'($urandom); st_i = rnd_st();
         start1 = 1'($urandom); st1_i = rnd_st();
      end
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_state_nz", 64'(nzw(st_o)), 64'(0));
      chk("rst_c", dut.c_q, 64'h0);
      chk("rst1_busy", 64'(busy1), 64'(0));
      chk("rst1_state_nz", 64'(nzw(st1_o)), 64'(0));
      start = 1'b0; start1 = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'(0));
      chk("post_rst_done", 64'(done), 64'(0));

      // single round from the zero state
      start1 = 1'b1; st1_i = '0;
      @(negedge clk);
      start1 = 1'b0; st1_i = rnd_st();
      n = 1; got1 = 1'b0;
      while (n <= 10 && !got1) begin
         if (done1) got1 = 1'b1;
         else begin @(negedge clk); n++; end
      end
      chk("r1_latency", 64'(n), 64'(2));
      e1 = model('0, 1);
      chk_state("r1", st1_o, e1);
      chk("r1_s16", st1_o[64*16 +: 64], 64'hFFFFFFFFFFFFFFFF);
      chk("r1_s22", st1_o[64*22 +: 64], 64'hFFFFFFFFFFFFFFFF);
      chk("r1_s23", st1_o[64*23 +: 64], 64'h4E6B4537F5F70AC4);
      chk("r1_c", dut1.c_q, 64'hF612BD1B9CE55141);

      // full permutation: zero and random states
      run24("zero", '0, 1'b0);
      for (int i = 0; i < 20; i++) run24($sformatf("rand%0d", i), rnd_st(), 1'b0);

      // starts while busy must be ignored
      for (int i = 0; i < 3; i++) run24($sformatf("dist%0d", i), rnd_st(), 1'b1);

      // back-to-back with start held high
      @(negedge clk);
      v = rnd_st(); start = 1'b1; st_i = v; q.push_back(v);
      n = 0; res = 0; guard = 0;
      while (res < 3 && guard < 200) begin
         @(negedge clk);
         n++; guard++;
         if (done) begin
            chk($sformatf("b2b%0d_gap", res), 64'(n), 64'(25));
            chk_state($sformatf("b2b%0d", res), st_o, model(q.pop_front(), 24));
            res++; n = 0;
            if (res < 3) begin
               v = rnd_st(); st_i = v; q.push_back(v);
            end else begin
               start = 1'b0;
            end
         end else begin
            st_i = rnd_st();
         end
      end
      start = 1'b0;
      chk("b2b_results", 64'(res), 64'(3));
      @(negedge clk);

      // reset in the middle of a run
      start = 1'b1; st_i = rnd_st();
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_done", 64'(done), 64'(0));
      chk("mid_rst_state_nz", 64'(nzw(st_o)), 64'(0));
      chk("mid_rst_c", dut.c_q, 64'h0);
      dcount = 0;
      repeat (30) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      chk("mid_rst_quiet", 64'(dcount), 64'(0));
      run24("after_rst", rnd_st(), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
